tx_gearbox: RTL and testbench

TX_GEARBOX -- requirements
Module: tx_gearbox

---
 rtl/tx_gearbox.sv | 84 ++++++++
 tb/tb_tx_gearbox.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/tx_gearbox.sv
// 66b-block to 32b-word gearbox with optional x^58+x^39+1 payload scrambler.
// Bits are held MSB-aligned in a 98-bit buffer; the oldest bit sits at bit 97.
module tx_gearbox #(
    parameter int          SCRAMBLE = 1,
    parameter logic [57:0] SEED     = 58'h3FF_FFFF_FFFF_FFFF
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [1:0]  header_i,
    input  logic [63:0] data_i,
    input  logic        data_valid_i,
    output logic        ready_o,
    output logic [31:0] word_o,
    output logic        word_valid_o,
    output logic        underrun_o
);
    localparam int BUF_W = 98;

    logic [BUF_W-1:0] r_buf;
    logic [6:0]       r_cnt;
    logic [57:0]      r_scr;
    logic [31:0]      r_word;
    logic             r_wv;
    logic             r_und;

    logic             w_emit;
    logic             w_accept;
    logic [6:0]       w_rem;
    logic [63:0]      w_payload;
    logic [57:0]      w_scr_nxt;
    logic [BUF_W-1:0] w_shift;
    logic [BUF_W-1:0] w_blk;
    logic [BUF_W-1:0] w_buf_nxt;
    logic [6:0]       w_cnt_nxt;

    assign ready_o      = (r_cnt < 7'd64);
    assign w_emit       = (r_cnt >= 7'd32);
    assign w_accept     = data_valid_i && ready_o;
    assign word_o       = r_word;
    assign word_valid_o = r_wv;
    assign underrun_o   = r_und;

    // Whole payload scrambled in one cycle, bit 63 first (transmit order).
    always_comb begin
        w_payload = data_i;
        w_scr_nxt = r_scr;
        if (SCRAMBLE != 0) begin
            for (int i = 0; i < 64; i++) begin
                w_payload[63-i] = data_i[63-i] ^ w_scr_nxt[38] ^ w_scr_nxt[57];
                w_scr_nxt       = {w_scr_nxt[56:0], w_payload[63-i]};
            end
        end
    end

    // Emit is decided on the pre-accept count; the new block lands right
    // behind whatever survives the emit.
    always_comb begin
        w_rem     = w_emit ? (r_cnt - 7'd32) : r_cnt;
        w_shift   = w_emit ? {r_buf[BUF_W-33:0], 32'd0} : r_buf;
        w_blk     = {header_i, w_payload, 32'd0} >> w_rem;
        w_buf_nxt = w_shift | (w_accept ? w_blk : '0);
        w_cnt_nxt = w_rem + (w_accept ? 7'd66 : 7'd0);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_buf  <= '0;
            r_cnt  <= '0;
            r_scr  <= SEED;
            r_word <= '0;
            r_wv   <= 1'b0;
            r_und  <= 1'b0;
        end else begin
            r_buf <= w_buf_nxt;
            r_cnt <= w_cnt_nxt;
            if (w_emit)
                r_word <= r_buf[BUF_W-1:BUF_W-32];
            r_wv  <= w_emit;
            r_und <= r_wv && !w_emit;
            if (w_accept)
                r_scr <= w_scr_nxt;
        end
    end
endmodule

// File: tb/tb_tx_gearbox.sv
// Directed bench for tx_gearbox: plain and scrambled instances share stimulus;
// the plain one is also checked word-by-word against a bit-queue reference.
module tb_tx_gearbox;
    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic [1:0]  header_i = 2'b01;
    logic [63:0] data_i = '0;
    logic        data_valid_i = 1'b0;
    logic        rdy0, wv0, und0, rdy1, wv1, und1;
    logic [31:0] word0, word1;

    always #5 clk_i = ~clk_i;

    tx_gearbox #(.SCRAMBLE(0)) u0 (
        .clk_i(clk_i), .rst_i(rst_i), .header_i(header_i), .data_i(data_i),
        .data_valid_i(data_valid_i), .ready_o(rdy0), .word_o(word0),
        .word_valid_o(wv0), .underrun_o(und0));

    tx_gearbox #(.SCRAMBLE(1)) u1 (
        .clk_i(clk_i), .rst_i(rst_i), .header_i(header_i), .data_i(data_i),
        .data_valid_i(data_valid_i), .ready_o(rdy1), .word_o(word1),
        .word_valid_o(wv1), .underrun_o(und1));

    typedef struct {
        logic [1:0]  hdr;
        logic [63:0] data;
        logic [31:0] w0, w1;
        bit          chk_s;
        logic [31:0] s0, s1;
    } vec_t;

    vec_t        vecs[5];
    int          checks = 0, failures = 0;
    bit          q[$];
    logic        acc;
    logic [31:0] e;
    int          words, drops, low_ready, accepted, und_cnt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // One clock: record an accepted block in the reference queue, then after
    // the edge compare any emitted word of the plain instance.
    task automatic tick();
        acc = !rst_i && data_valid_i && rdy0;
        if (acc) begin
            for (int i = 1; i >= 0; i--) q.push_back(header_i[i]);
            for (int i = 63; i >= 0; i--) q.push_back(data_i[i]);
        end
        @(posedge clk_i); #1;
        if (wv0) begin
            if (q.size() < 32) chk("stream_underflow", 32'(q.size()), 32'd32);
            e = '0;
            for (int i = 0; i < 32; i++) begin
                e = {e[30:0], 1'b0};
                if (q.size() > 0) e[0] = q.pop_front();
            end
            chk("stream_word", word0, e);
        end
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        data_valid_i = 1'b0;
        q.delete();
        repeat (2) @(posedge clk_i);
        #1 rst_i = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{2'b01, 64'hFFFF_FFFF_0000_0000, 32'h7FFF_FFFF, 32'hC000_0000, 1'b1, 32'h7FFF_FFFF, 32'hC000_0000};
        vecs[1] = '{2'b10, 64'h0, 32'h8000_0000, 32'h0000_0000, 1'b1, 32'h8000_0000, 32'h007F_FFF0};
        vecs[2] = '{2'b01, 64'h0123_4567_89AB_CDEF, 32'h4048_D159, 32'hE26A_F37B, 1'b0, 32'h0, 32'h0};
        vecs[3] = '{2'b10, 64'hFFFF_FFFF_FFFF_FFFF, 32'hBFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hBFFF_FFFF, 32'hFFFF_FFFF};
        vecs[4] = '{2'b01, 64'hAAAA_AAAA_AAAA_AAAA, 32'h6AAA_AAAA, 32'hAAAA_AAAA, 1'b0, 32'h0, 32'h0};

        #3;
        chk("rst_wv", 32'(wv0), 32'd0);
        chk("rst_word", word0, 32'd0);
        chk("rst_ready", 32'(rdy0), 32'd1);
        do_reset();

        // Single isolated blocks from reset.
        for (int v = 0; v < 5; v++) begin
            do_reset();
            header_i = vecs[v].hdr; data_i = vecs[v].data; data_valid_i = 1'b1;
            chk("ready_empty", 32'(rdy0), 32'd1);
            tick();
            data_valid_i = 1'b0;
            chk("latency_wv0", 32'(wv0), 32'd0);
            chk("ready_full", 32'(rdy0), 32'd0);
            tick();
            chk("first_wv", 32'(wv0), 32'd1);
            chk("first_word", word0, vecs[v].w0);
            if (vecs[v].chk_s) chk("scr_first_word", word1, vecs[v].s0);
            tick();
            chk("second_word", word0, vecs[v].w1);
            if (vecs[v].chk_s) chk("scr_second_word", word1, vecs[v].s1);
            tick();
            chk("idle_wv", 32'(wv0), 32'd0);
            chk("idle_hold", word0, vecs[v].w1);
            chk("underrun_pulse", 32'(und0), 32'd1);
            chk("residual_2", 32'(q.size()), 32'd2);
            tick();
            chk("underrun_once", 32'(und0), 32'd0);
        end

        // Sustained input: 48 incrementing blocks -> 99 unbroken words.
        do_reset();
        header_i = 2'b01; data_i = 64'd0; data_valid_i = 1'b1;
        words = 0; drops = 0; low_ready = 0; accepted = 0;
        for (int cyc = 0; cyc < 400 && words < 99; cyc++) begin
            if (!rdy0) low_ready++;
            tick();
            if (acc) begin
                accepted++;
                if (accepted == 48) data_valid_i = 1'b0;
                else data_i = 64'(accepted);
            end
            if (wv0) words++;
            else if (words > 0) drops++;
        end
        chk("sustain_words", 32'(words), 32'd99);
        chk("sustain_drops", 32'(drops), 32'd0);
        chk("sustain_accepted", 32'(accepted), 32'd48);
        chk("sustain_ready_low", 32'(low_ready > 0), 32'd1);
        chk("sustain_drained", 32'(q.size()), 32'd0);
        tick();
        chk("sustain_end_underrun", 32'(und0), 32'd1);

        // Stop mid-stream, then resume behind the residual bits.
        do_reset();
        header_i = 2'b10; data_i = 64'd0; data_valid_i = 1'b1; accepted = 0;
        for (int cyc = 0; cyc < 20 && accepted < 3; cyc++) begin
            tick();
            if (acc) begin
                accepted++;
                data_i = 64'(accepted);
                if (accepted == 3) data_valid_i = 1'b0;
            end
        end
        und_cnt = 0;
        for (int cyc = 0; cyc < 12; cyc++) begin
            tick();
            if (und0) und_cnt++;
        end
        chk("stop_underrun_count", 32'(und_cnt), 32'd1);
        chk("stop_wv", 32'(wv0), 32'd0);
        chk("stop_residual", 32'(q.size()), 32'd6);
        header_i = 2'b01; data_i = '1; data_valid_i = 1'b1;
        tick();
        data_valid_i = 1'b0;
        tick();
        chk("resume_word", word0, 32'h09FF_FFFF);
        repeat (3) tick();
        chk("resume_residual", 32'(q.size()), 32'd8);

        // Reset mid-stream at count 34.
        do_reset();
        header_i = 2'b10; data_i = 64'h0123_4567_89AB_CDEF; data_valid_i = 1'b1;
        tick();
        data_valid_i = 1'b0;
        tick();
        chk("pre_reset_wv", 32'(wv0), 32'd1);
        rst_i = 1'b1;
        #1;
        chk("async_rst_wv", 32'(wv0), 32'd0);
        chk("async_rst_word", word0, 32'd0);
        chk("async_rst_ready", 32'(rdy0), 32'd1);
        chk("async_rst_scr_word", word1, 32'd0);
        q.delete();
        header_i = 2'b01; data_i = '1; data_valid_i = 1'b1;
        @(posedge clk_i); #1;
        rst_i = 1'b0; data_valid_i = 1'b0;
        tick();
        tick();
        chk("rst_inhibit_wv", 32'(wv0), 32'd0);
        data_valid_i = 1'b1;
        tick();
        data_valid_i = 1'b0;
        tick();
        chk("post_rst_word", word0, 32'h7FFF_FFFF);
        chk("post_rst_scr_word", word1, 32'h7FFF_FFFF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
